display_lcd_bridge: RTL and testbench

Target-side register consumer for the display link. Takes decoded register writes (`wvalid`/`addr`/`wdata`) from `display_target` and returns `rdata` to it. Queues command/data bytes in a small FIFO and shifts them out to the LCD controller over a 4-wire SPI (mode 0, MSB first, separate D/C line). Runs entirely in the `c125` domain of the target.

---
 rtl/display_pkg.sv | 27 ++
 rtl/display_fifo.sv | 75 +++++++
 rtl/display_lcd_bridge.sv | 252 +++++++++++++++++++++++++
 tb/tb_display_lcd_bridge.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared constants and types for the display link target-side
//                LCD bridge: register addresses, bus widths, FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    // Register map seen by display_target
    localparam logic [ADDR_W-1:0] DISP_A_TX     = 8'h00;
    localparam logic [ADDR_W-1:0] DISP_A_CTRL   = 8'h01;
    localparam logic [ADDR_W-1:0] DISP_A_STATUS = 8'h02;

    // Serialiser states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } disp_state_t;

endpackage
`default_nettype wire

// File: rtl/display_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : display_fifo
//  Description : Synchronous first-word-fall-through FIFO holding {dc, byte}
//                entries for the LCD serialiser.
//  Ports       : clk/rst      - clock, asynchronous active-high reset
//                i_push/i_data - write strobe and entry
//                i_pop/o_data  - read strobe and head entry (valid if !o_empty)
//                o_level/o_full/o_empty - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module display_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    // Pointers carry one extra wrap bit: equal addresses with differing wrap
    // bits means full, identical pointers means empty.
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // A pop frees a slot in the same cycle, so a push to a full FIFO that
    // coincides with a pop is still accepted.
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign o_data  = r_mem[r_rptr[AW-1:0]];
    assign o_level = r_wptr - r_rptr;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/display_lcd_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : display_lcd_bridge
//  Description : Register consumer for the display link target. Queues LCD
//                command/data bytes and shifts them out on a 4-wire SPI
//                (mode 0, MSB first, separate D/C line).
//  Ports       : c125/reset    - target clock, asynchronous active-high reset
//                wvalid/addr/wdata - register write from display_target
//                rdata          - registered read data for addr
//                lcd_sck/lcd_mosi/lcd_cs_n/lcd_dc - SPI to LCD controller
//                irq            - FIFO low-water interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module display_lcd_bridge
    import display_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int DIV_RESET = 3
) (
    input  logic              c125,
    input  logic              reset,
    input  logic              wvalid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              lcd_sck,
    output logic              lcd_mosi,
    output logic              lcd_cs_n,
    output logic              lcd_dc,
    output logic              irq
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    localparam logic [8:0] c_irq_thresh = 9'(DEPTH / 4);
    localparam logic [7:0] c_div_reset  = 8'(DIV_RESET);

    // ------------------------------------------------------------------
    // Register interface
    // ------------------------------------------------------------------
    logic [7:0]        r_div;
    logic              r_irq_en;
    logic              r_ovf;
    logic              r_irq;
    logic [DATA_W-1:0] r_rdata;

    logic              w_push;
    logic              w_pop;
    logic [8:0]        w_fifo_rd;
    logic [LVL_W-1:0]  w_level;
    logic [8:0]        w_level9;
    logic              w_full;
    logic              w_empty;
    logic              w_busy;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              w_unused_wdata;

    assign w_push   = wvalid && (addr == DISP_A_TX);
    assign w_level9 = 9'(w_level);

    assign w_unused_wdata = &{1'b0, wdata[DATA_W-1:9]};

    display_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk     (c125),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (wdata[8:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rd),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ------------------------------------------------------------------
    // Serialiser state
    // ------------------------------------------------------------------
    disp_state_t r_state;
    disp_state_t w_state_nxt;
    logic [7:0]  r_hc;
    logic [7:0]  w_hc_nxt;
    logic [3:0]  r_bc;
    logic [3:0]  w_bc_nxt;
    logic [7:0]  r_shreg;
    logic [7:0]  w_shreg_nxt;
    logic [7:0]  r_div_cur;
    logic [7:0]  w_div_cur_nxt;
    logic        r_sck;
    logic        w_sck_nxt;
    logic        r_mosi;
    logic        w_mosi_nxt;
    logic        r_cs_n;
    logic        w_cs_n_nxt;
    logic        r_dc;
    logic        w_dc_nxt;
    logic        w_hc_zero;

    assign w_hc_zero = (r_hc == 8'd0);
    assign w_busy    = (r_state != IDLE) || (w_level9 != 9'd0);

    always_comb begin
        w_state_nxt   = r_state;
        w_hc_nxt      = r_hc;
        w_bc_nxt      = r_bc;
        w_shreg_nxt   = r_shreg;
        w_div_cur_nxt = r_div_cur;
        w_sck_nxt     = r_sck;
        w_mosi_nxt    = r_mosi;
        w_cs_n_nxt    = r_cs_n;
        w_dc_nxt      = r_dc;
        w_pop         = 1'b0;

        case (r_state)
            IDLE: begin
                w_cs_n_nxt = 1'b1;
                w_sck_nxt  = 1'b0;
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shreg_nxt   = w_fifo_rd[7:0];
                    w_dc_nxt      = w_fifo_rd[8];
                    w_mosi_nxt    = w_fifo_rd[7];
                    w_cs_n_nxt    = 1'b0;
                    w_hc_nxt      = r_div;
                    w_div_cur_nxt = r_div;
                    w_state_nxt   = SETUP;
                end
            end

            SETUP: begin
                if (w_hc_zero) begin
                    w_hc_nxt    = r_div_cur;
                    w_bc_nxt    = 4'd0;
                    w_state_nxt = SHIFT;
                end else begin
                    w_hc_nxt = r_hc - 8'd1;
                end
            end

            SHIFT: begin
                if (w_hc_zero) begin
                    w_sck_nxt = ~r_sck;
                    w_hc_nxt  = r_div_cur;
                    w_bc_nxt  = r_bc + 4'd1;
                    // Odd half-periods are falling edges: present next bit
                    if (r_bc[0]) begin
                        w_mosi_nxt  = r_shreg[6];
                        w_shreg_nxt = {r_shreg[6:0], 1'b0};
                    end
                    if (r_bc == 4'd15) begin
                        if (!w_empty) begin
                            // Chain straight into the next byte, CS stays low
                            w_pop         = 1'b1;
                            w_shreg_nxt   = w_fifo_rd[7:0];
                            w_dc_nxt      = w_fifo_rd[8];
                            w_mosi_nxt    = w_fifo_rd[7];
                            w_hc_nxt      = r_div;
                            w_div_cur_nxt = r_div;
                            w_state_nxt   = SETUP;
                        end else begin
                            w_state_nxt = HOLD;
                        end
                    end
                end else begin
                    w_hc_nxt = r_hc - 8'd1;
                end
            end

            HOLD: begin
                if (w_hc_zero) begin
                    w_cs_n_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_hc_nxt = r_hc - 8'd1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge c125 or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_hc      <= 8'd0;
            r_bc      <= 4'd0;
            r_shreg   <= 8'd0;
            r_div_cur <= c_div_reset;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_dc      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hc      <= w_hc_nxt;
            r_bc      <= w_bc_nxt;
            r_shreg   <= w_shreg_nxt;
            r_div_cur <= w_div_cur_nxt;
            r_sck     <= w_sck_nxt;
            r_mosi    <= w_mosi_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_dc      <= w_dc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Control/status registers and read mux
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata_nxt = '0;
        case (addr)
            DISP_A_CTRL:   w_rdata_nxt = {23'd0, r_irq_en, r_div};
            DISP_A_STATUS: w_rdata_nxt = {14'd0, r_ovf, w_busy, 7'd0, w_level9};
            default:       w_rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge c125 or posedge reset) begin
        if (reset) begin
            r_div    <= c_div_reset;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_irq    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rdata <= w_rdata_nxt;
            r_irq   <= (w_level9 <= c_irq_thresh) && r_irq_en;
            if (wvalid && (addr == DISP_A_CTRL)) begin
                r_div    <= wdata[7:0];
                r_irq_en <= wdata[8];
            end
            if (wvalid && (addr == DISP_A_STATUS)) begin
                r_ovf <= 1'b0;
            end else if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign rdata    = r_rdata;
    assign irq      = r_irq;
    assign lcd_sck  = r_sck;
    assign lcd_mosi = r_mosi;
    assign lcd_cs_n = r_cs_n;
    assign lcd_dc   = r_dc;

endmodule
`default_nettype wire

// File: tb/tb_display_lcd_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_lcd_bridge
//  Description : Directed self-checking bench for display_lcd_bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_lcd_bridge;
    import display_pkg::*;

    logic        c125   = 1'b0;
    logic        reset  = 1'b1;
    logic        wvalid = 1'b0;
    logic [7:0]  addr   = 8'h00;
    logic [31:0] wdata  = 32'h0;
    logic [31:0] rdata;
    logic        lcd_sck;
    logic        lcd_mosi;
    logic        lcd_cs_n;
    logic        lcd_dc;
    logic        irq;

    always #4 c125 = ~c125;

    display_lcd_bridge #(
        .DEPTH     (16),
        .DIV_RESET (3)
    ) dut (
        .c125     (c125),
        .reset    (reset),
        .wvalid   (wvalid),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .lcd_sck  (lcd_sck),
        .lcd_mosi (lcd_mosi),
        .lcd_cs_n (lcd_cs_n),
        .lcd_dc   (lcd_dc),
        .irq      (irq)
    );

    int n_vec = 0;
    int n_err = 0;
    int pcyc  = 0;

    always @(posedge c125) pcyc <= pcyc + 1;

    // Line monitor: event times are the index of the clock edge that made them
    logic q_bits[$];
    logic q_dc[$];
    int   q_rise[$];
    int   q_fall[$];
    int   q_csr[$];
    logic p_sck  = 1'b0;
    logic p_cs_n = 1'b1;

    always @(negedge c125) begin
        if (lcd_sck && !p_sck) begin
            q_bits.push_back(lcd_mosi);
            q_dc.push_back(lcd_dc);
            q_rise.push_back(pcyc);
        end
        if (!lcd_cs_n && p_cs_n) q_fall.push_back(pcyc);
        if (lcd_cs_n && !p_cs_n) q_csr.push_back(pcyc);
        p_sck  <= lcd_sck;
        p_cs_n <= lcd_cs_n;
    end

    function automatic int rise_at(input int i);
        return (i < q_rise.size()) ? q_rise[i] : -100000;
    endfunction
    function automatic int fall_at(input int i);
        return (i < q_fall.size()) ? q_fall[i] : -100000;
    endfunction
    function automatic int csr_at(input int i);
        return (i < q_csr.size()) ? q_csr[i] : -100000;
    endfunction
    function automatic logic [31:0] pack_bits(input int base, input int n);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) begin
            v = {v[30:0], (base + i < q_bits.size()) ? q_bits[base + i] : 1'bx};
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge c125);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        wvalid = 1'b1;
        addr   = a;
        wdata  = d;
        step();
        wvalid = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        addr = a;
        step();
        d = rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_csr(input int target, input int budget);
        int i = 0;
        while (q_csr.size() < target && i < budget) begin
            step();
            i++;
        end
        chk("cs_rise_seen", 32'(q_csr.size()), 32'(target));
    endtask

    task automatic wait_rises(input int target, input int budget);
        int i = 0;
        while (q_rise.size() < target && i < budget) begin
            step();
            i++;
        end
        chk("sck_rise_seen", 32'(q_rise.size()), 32'(target));
    endtask

    initial begin
        logic [31:0] d;
        int br, bf, bc, tw;
        logic prev_irq;
        logic [3:0] dcs;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_cs_n", 32'(lcd_cs_n), 32'd1);
        chk("rst_sck",  32'(lcd_sck),  32'd0);
        chk("rst_mosi", 32'(lcd_mosi), 32'd0);
        chk("rst_dc",   32'(lcd_dc),   32'd0);
        chk("rst_irq",  32'(irq),      32'd0);
        chk("rst_rdata", rdata,        32'd0);
        reset = 1'b0;
        step();
        rd(DISP_A_CTRL, d);   chk("rst_ctrl",   d, 32'h0000_0003);
        rd(DISP_A_STATUS, d); chk("rst_status", d, 32'h0000_0000);
        rd(8'h07, d);         chk("unmapped_rd", d, 32'h0);

        // ---------------- single byte, div=0 ----------------
        wr(DISP_A_CTRL, 32'h0);
        br = q_rise.size(); bf = q_fall.size(); bc = q_csr.size();
        tw = pcyc;
        wr(DISP_A_TX, 32'h1A5);
        rd(DISP_A_STATUS, d);  chk("s1_status_busy", d, 32'h0001_0001);
        wait_csr(bc + 1, 100);
        chk("s1_cs_fall_lat", 32'(fall_at(bf) - tw), 32'd2);
        chk("s1_first_rise",  32'(rise_at(br) - fall_at(bf)), 32'd2);
        chk("s1_rise_cnt",    32'(q_rise.size() - br), 32'd8);
        chk("s1_bits",        pack_bits(br, 8), 32'h0000_00A5);
        chk("s1_dc",          32'((br < q_dc.size()) ? q_dc[br] : 1'b0), 32'd1);
        chk("s1_cs_window",   32'(csr_at(bc) - fall_at(bf)), 32'd18);
        rd(DISP_A_STATUS, d);  chk("s1_status_idle", d, 32'h0);

        // ---------------- burst, div=2 ----------------
        wr(DISP_A_CTRL, 32'h2);
        br = q_rise.size(); bf = q_fall.size(); bc = q_csr.size();
        wr(DISP_A_TX, 32'h011);
        wr(DISP_A_TX, 32'h122);
        wr(DISP_A_TX, 32'h133);
        wr(DISP_A_TX, 32'h044);
        wait_csr(bc + 1, 400);
        chk("b_fall_cnt",   32'(q_fall.size() - bf), 32'd1);
        chk("b_rise_cnt",   32'(q_rise.size() - br), 32'd32);
        chk("b_bits",       pack_bits(br, 32), 32'h1122_3344);
        for (int j = 0; j < 4; j++) begin
            dcs[3 - j] = (br + 8 * j < q_dc.size()) ? q_dc[br + 8 * j] : 1'b0;
        end
        chk("b_dc_seq",     32'(dcs), 32'b0110);
        chk("b_first_rise", 32'(rise_at(br) - fall_at(bf)), 32'd6);
        chk("b_period0",    32'(rise_at(br + 8) - rise_at(br)), 32'd51);
        chk("b_period2",    32'(rise_at(br + 24) - rise_at(br + 16)), 32'd51);
        chk("b_cs_window",  32'(csr_at(bc) - fall_at(bf)), 32'd207);

        // ---------------- overflow, div=255 ----------------
        do_reset();
        wr(DISP_A_CTRL, 32'h0FF);
        for (int i = 0; i < 18; i++) wr(DISP_A_TX, 32'(i));
        rd(DISP_A_STATUS, d);  chk("ovf_status", d, 32'h0003_0010);
        chk("ovf_irq_off", 32'(irq), 32'd0);
        wr(DISP_A_STATUS, 32'h0);
        rd(DISP_A_STATUS, d);  chk("ovf_cleared", d, 32'h0001_0010);

        // ---------------- IRQ, div=15 ----------------
        do_reset();
        wr(DISP_A_CTRL, 32'h00F);
        for (int i = 0; i < 6; i++) wr(DISP_A_TX, 32'(8'h30 + i));
        rd(DISP_A_STATUS, d);  chk("irq_level5", d, 32'h0001_0005);
        chk("irq_dis", 32'(irq), 32'd0);
        wr(DISP_A_CTRL, 32'h10F);
        step();
        chk("irq_above_thr", 32'(irq), 32'd0);
        addr = DISP_A_STATUS;
        prev_irq = irq;
        for (int i = 0; i < 400; i++) begin
            prev_irq = irq;
            step();
            if (rdata[8:0] == 9'd4) break;
        end
        chk("irq_level4",  32'(rdata[8:0]), 32'd4);
        chk("irq_pre",     32'(prev_irq), 32'd0);
        chk("irq_rise",    32'(irq), 32'd1);
        wr(DISP_A_CTRL, 32'h00F);
        chk("irq_lag",     32'(irq), 32'd1);
        step();
        chk("irq_en_off",  32'(irq), 32'd0);

        // ---------------- reset mid-byte ----------------
        do_reset();
        wr(DISP_A_CTRL, 32'h3);
        br = q_rise.size();
        wr(DISP_A_TX, 32'h1FF);
        addr = DISP_A_STATUS;
        wait_rises(br + 4, 200);
        chk("mid_sck",    32'(lcd_sck),  32'd1);
        chk("mid_cs_n",   32'(lcd_cs_n), 32'd0);
        chk("mid_dc",     32'(lcd_dc),   32'd1);
        chk("mid_rdata",  rdata,         32'h0001_0000);
        #1 reset = 1'b1;
        #1;
        chk("ar_sck",   32'(lcd_sck),  32'd0);
        chk("ar_cs_n",  32'(lcd_cs_n), 32'd1);
        chk("ar_mosi",  32'(lcd_mosi), 32'd0);
        chk("ar_dc",    32'(lcd_dc),   32'd0);
        chk("ar_rdata", rdata,         32'd0);
        step();
        reset = 1'b0;
        br = q_rise.size(); bf = q_fall.size();
        repeat (60) step();
        chk("ar_no_sck",   32'(q_rise.size() - br), 32'd0);
        chk("ar_no_cs",    32'(q_fall.size() - bf), 32'd0);
        chk("ar_rdata_post", rdata, 32'd0);
        rd(DISP_A_STATUS, d);  chk("ar_status", d, 32'h0);
        rd(DISP_A_CTRL, d);    chk("ar_ctrl",   d, 32'h3);

        // ---------------- divider change mid-byte ----------------
        wr(DISP_A_CTRL, 32'h1);
        br = q_rise.size(); bf = q_fall.size(); bc = q_csr.size();
        wr(DISP_A_TX, 32'h0AA);
        wr(DISP_A_TX, 32'h055);
        wait_rises(br + 3, 100);
        wr(DISP_A_CTRL, 32'h3);
        wait_csr(bc + 1, 300);
        chk("dv_bits",      pack_bits(br, 16), 32'h0000_AA55);
        chk("dv_first",     32'(rise_at(br) - fall_at(bf)), 32'd4);
        chk("dv_per_b0a",   32'(rise_at(br + 1) - rise_at(br)), 32'd4);
        chk("dv_per_b0b",   32'(rise_at(br + 7) - rise_at(br + 6)), 32'd4);
        chk("dv_per_b1",    32'(rise_at(br + 9) - rise_at(br + 8)), 32'd8);
        chk("dv_b1_start",  32'(rise_at(br + 8) - rise_at(br)), 32'd38);
        chk("dv_cs_window", 32'(csr_at(bc) - fall_at(bf)), 32'd106);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
